// File: rtl/packet_pkg.sv
// Shared frame layout, CRC generator and receiver state encoding for the
// packet transmitter, builder and receiver.
package packet_pkg;

  localparam int FRAME_LEN = 79;

  // Frame bit positions, counted with the start bit at FRAME_LEN-1.
  localparam int SRC_HI  = 77;
  localparam int SRC_LO  = 74;
  localparam int DST_HI  = 73;
  localparam int DST_LO  = 70;
  localparam int SIZE_HI = 69;
  localparam int SIZE_LO = 68;
  localparam int DATA_HI = 67;
  localparam int DATA_LO = 4;
  localparam int CRC_HI  = 3;
  localparam int CRC_LO  = 1;
  localparam int STOP    = 0;

  // Codeword covered by the CRC: data plus check bits.
  localparam int CW_HI = DATA_HI;
  localparam int CW_LO = CRC_LO;

  localparam logic [3:0] CRC_POLY = 4'b1001;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    RESYNC
  } state_t;

endpackage

// File: rtl/crc3_serial.sv
// Bit-serial divider producing the 3-bit remainder of the bits fed so far,
// MSB first, modulo a degree-3 generator polynomial.
module crc3_serial #(
  parameter logic [3:0] POLY = 4'b1001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [2:0] rem
);

  // NOTE: sequential state is assigned with <= only, so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem <= '0;
    end else if (clr) begin
      rem <= '0;
    end else if (en) begin
      rem <= {rem[1:0], bit_in} ^ (rem[2] ? POLY[2:0] : 3'b000);
    end
  end

endmodule

// File: rtl/packet_receive.sv
// Serial packet receiver: frames MSB first on an idle-high line, checks the
// stop bit and CRC, and presents the decoded fields with a one-cycle strobe.
module packet_receive #(
  parameter int         FRAME_LEN = 79,
  parameter logic [3:0] CRC_POLY  = 4'b1001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        serial_in,
  input  logic [3:0]  my_address,
  output logic        pkt_valid,
  output logic [3:0]  src_addr,
  output logic [3:0]  dst_addr,
  output logic [1:0]  data_size,
  output logic [63:0] data_out,
  output logic        crc_ok,
  output logic        is_ack,
  output logic        is_nack,
  output logic        frame_err,
  output logic        busy
);

  import packet_pkg::*;

  localparam int CNT_W = $clog2(FRAME_LEN);

  state_t             state, state_next;
  logic [CNT_W-1:0]   bit_cnt;
  // Holds frame bits 77..1 only: frame_q[i-1] is frame bit i at the stop edge.
  logic [FRAME_LEN-3:0] frame_q;
  logic [2:0]         crc_rem;
  logic               start, shift, stop_good, stop_bad, crc_en;

  always_comb begin
    // NOTE: every combinational output gets a default before the case, so
    // no path leaves a value unassigned and no latch is inferred.
    state_next = state;
    start      = 1'b0;
    shift      = 1'b0;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (!serial_in) begin
          state_next = RECV;
          start      = 1'b1;
        end
      end
      RECV: begin
        if (bit_cnt != '0) begin
          shift = 1'b1;
        end else if (serial_in) begin
          state_next = IDLE;
          stop_good  = 1'b1;
        end else begin
          state_next = RESYNC;
          stop_bad   = 1'b1;
        end
      end
      RESYNC: begin
        if (serial_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      frame_q <= '1;
    end else if (start) begin
      bit_cnt <= CNT_W'(FRAME_LEN - 2);
    end else if (shift) begin
      bit_cnt <= bit_cnt - 1'b1;
      frame_q <= {frame_q[FRAME_LEN-4:0], serial_in};
    end
  end

  assign crc_en = shift && (bit_cnt <= CNT_W'(CW_HI)) && (bit_cnt >= CNT_W'(CW_LO));

  crc3_serial #(
    .POLY (CRC_POLY)
  ) u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start),
    .en     (crc_en),
    .bit_in (serial_in),
    .rem    (crc_rem)
  );

  // Fields latch on any well-framed packet; only the strobe depends on address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_valid <= 1'b0;
      frame_err <= 1'b0;
      src_addr  <= '0;
      dst_addr  <= '0;
      data_size <= '0;
      data_out  <= '0;
      crc_ok    <= 1'b0;
      is_ack    <= 1'b0;
      is_nack   <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      frame_err <= stop_bad;
      if (stop_good) begin
        src_addr  <= frame_q[SRC_HI-1:SRC_LO-1];
        dst_addr  <= frame_q[DST_HI-1:DST_LO-1];
        data_size <= frame_q[SIZE_HI-1:SIZE_LO-1];
        data_out  <= frame_q[DATA_HI-1:DATA_LO-1];
        crc_ok    <= (crc_rem == 3'b000);
        is_ack    <= &frame_q[CW_HI-1:CW_LO-1];
        is_nack   <= ~|frame_q[CW_HI-1:CW_LO-1];
        pkt_valid <= (frame_q[DST_HI-1:DST_LO-1] == my_address);
      end
    end
  end

  assign busy = (state == RECV) || (state == RESYNC);

endmodule

// File: tb/tb_packet_receive.sv
// Self-checking bench for packet_receive: directed scenarios plus random
// frames compared against a field-level model of the frame format.
module tb_packet_receive;

  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [1:0]  size;
    logic [63:0] data;
    logic        crc_ok;
    logic        ack;
    logic        nack;
  } fields_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        serial_in;
  logic [3:0]  my_address;
  logic        pkt_valid, crc_ok, is_ack, is_nack, frame_err, busy;
  logic [3:0]  src_addr, dst_addr;
  logic [1:0]  data_size;
  logic [63:0] data_out;
  fields_t     obs;
  fields_t     exp_fields;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pv_count = 0;
  int fe_count = 0;

  packet_receive dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial_in  (serial_in),
    .my_address (my_address),
    .pkt_valid  (pkt_valid),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .data_size  (data_size),
    .data_out   (data_out),
    .crc_ok     (crc_ok),
    .is_ack     (is_ack),
    .is_nack    (is_nack),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  assign obs = {src_addr, dst_addr, data_size, data_out, crc_ok, is_ack, is_nack};

  // Values seen at a rising edge are those held during the preceding cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pkt_valid) pv_count <= pv_count + 1;
    if (frame_err) fe_count <= fe_count + 1;
    if (pkt_valid || frame_err) begin
      checks++;
      if (pkt_valid && frame_err) begin
        failures++;
        $display("FAIL pulse_overlap: pkt_valid=%b frame_err=%b, required not both high", pkt_valid, frame_err);
      end
    end
  end

  // x^k mod (x^3+1) = x^(k mod 3), so the remainder is a fold of bit positions mod 3.
  function automatic logic [2:0] mod_poly(input logic [66:0] cw);
    logic [2:0] r = 3'b000;
    for (int i = 0; i < 67; i++)
      if (cw[i]) r[i % 3] = ~r[i % 3];
    return r;
  endfunction

  function automatic logic [2:0] crc_for(input logic [63:0] data);
    return mod_poly({data, 3'b000});
  endfunction

  function automatic logic [78:0] make_frame(input logic [3:0] src, input logic [3:0] dst,
                                             input logic [1:0] size, input logic [63:0] data,
                                             input logic [2:0] crc, input logic stop);
    return {1'b0, src, dst, size, data, crc, stop};
  endfunction

  function automatic fields_t model(input logic [78:0] f);
    fields_t m;
    logic [66:0] cw = f[67:1];
    m.src    = f[77:74];
    m.dst    = f[73:70];
    m.size   = f[69:68];
    m.data   = f[67:4];
    m.crc_ok = (mod_poly(cw) == 3'b000);
    m.ack    = (cw == {67{1'b1}});
    m.nack   = (cw == '0);
    return m;
  endfunction

  // Called at a falling edge; returns at the falling edge after the stop-bit sample.
  task automatic send_frame(input logic [78:0] f);
    for (int i = 78; i >= 0; i--) begin
      serial_in = f[i];
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    serial_in = 1'b1;
    my_address = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pkt_valid, frame_err, busy, obs} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got pv=%b fe=%b busy=%b fields=%h, required all zero",
               pkt_valid, frame_err, busy, obs);
    end
    exp_fields = '0;
    rst_n = 1'b1;
    idle(2);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_directed;
    logic [78:0] f;
    my_address = 4'h5;
    f = make_frame(4'h2, 4'h5, 2'b01, 64'h1, 3'b001, 1'b1);
    exp_fields = model(f);
    send_frame(f);
    checks++;
    if (pkt_valid !== 1'b1) begin
      failures++;
      $display("FAIL directed_pkt_valid: got %b required 1", pkt_valid);
    end
    checks++;
    if ({data_out, crc_ok, is_ack, is_nack} !== {64'h1, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL directed_data_crc: got data=%h crc_ok=%b ack=%b nack=%b required data=1 crc_ok=1 ack=0 nack=0",
               data_out, crc_ok, is_ack, is_nack);
    end
    checks++;
    if (obs !== exp_fields) begin
      failures++;
      $display("FAIL directed_fields: got %h required %h", obs, exp_fields);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL directed_busy_after: got %b required 0", busy);
    end
    idle(1);
    checks++;
    if (pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL directed_pulse_width: pkt_valid got %b required 0", pkt_valid);
    end
    idle(2);
  endtask

  task automatic test_crc_error;
    logic [78:0] f;
    f = make_frame(4'h2, 4'h5, 2'b01, 64'h1, 3'b001, 1'b1);
    f[4] = ~f[4];
    exp_fields = model(f);
    send_frame(f);
    checks++;
    if ({pkt_valid, crc_ok} !== 2'b10) begin
      failures++;
      $display("FAIL crc_err_flags: got pv=%b crc_ok=%b required pv=1 crc_ok=0", pkt_valid, crc_ok);
    end
    checks++;
    if (obs !== exp_fields) begin
      failures++;
      $display("FAIL crc_err_fields: got %h required %h", obs, exp_fields);
    end
    idle(3);
  endtask

  task automatic test_address_miss;
    logic [78:0] f;
    int pv0;
    my_address = 4'h3;
    f = make_frame(4'h2, 4'h5, 2'b01, 64'h1, 3'b001, 1'b1);
    exp_fields = model(f);
    pv0 = pv_count;
    send_frame(f);
    checks++;
    if (pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL miss_pkt_valid: got %b required 0", pkt_valid);
    end
    checks++;
    if (dst_addr !== 4'h5 || obs !== exp_fields) begin
      failures++;
      $display("FAIL miss_fields: got %h required %h", obs, exp_fields);
    end
    idle(2);
    checks++;
    if (pv_count !== pv0) begin
      failures++;
      $display("FAIL miss_pulse_count: got %0d pulses required 0", pv_count - pv0);
    end
  endtask

  task automatic test_frame_error;
    logic [78:0] f;
    int fe0;
    my_address = 4'h5;
    f = make_frame(4'h9, 4'h5, 2'b10, {$urandom, $urandom}, 3'($urandom), 1'b0);
    fe0 = fe_count;
    send_frame(f);
    checks++;
    if ({frame_err, pkt_valid, busy} !== 3'b101) begin
      failures++;
      $display("FAIL ferr_pulse: got fe=%b pv=%b busy=%b required fe=1 pv=0 busy=1", frame_err, pkt_valid, busy);
    end
    checks++;
    if (obs !== exp_fields) begin
      failures++;
      $display("FAIL ferr_fields_held: got %h required %h", obs, exp_fields);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, frame_err} !== 2'b10) begin
        failures++;
        $display("FAIL ferr_resync_%0d: got busy=%b fe=%b required busy=1 fe=0", i, busy, frame_err);
      end
    end
    idle(1);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL ferr_back_to_idle: busy got %b required 0", busy);
    end
    checks++;
    if (fe_count - fe0 !== 1 || obs !== exp_fields) begin
      failures++;
      $display("FAIL ferr_count_fields: pulses=%0d fields=%h required 1 pulse fields=%h",
               fe_count - fe0, obs, exp_fields);
    end
    idle(2);
  endtask

  task automatic test_back_to_back;
    logic [78:0] f1, f2;
    int t1, t2;
    my_address = 4'($urandom);
    f1 = make_frame(4'($urandom), my_address, 2'($urandom), 64'h0, 3'b000, 1'b1);
    f2 = make_frame(4'($urandom), my_address, 2'($urandom), 64'h0, 3'b000, 1'b1);
    send_frame(f1);
    t1 = cyc;
    exp_fields = model(f1);
    checks++;
    if ({pkt_valid, is_nack, crc_ok} !== 3'b111 || obs !== exp_fields) begin
      failures++;
      $display("FAIL b2b_first: pv=%b nack=%b crc_ok=%b fields=%h required 1 1 1 fields=%h",
               pkt_valid, is_nack, crc_ok, obs, exp_fields);
    end
    send_frame(f2);
    t2 = cyc;
    exp_fields = model(f2);
    checks++;
    if ({pkt_valid, is_nack, crc_ok} !== 3'b111 || obs !== exp_fields) begin
      failures++;
      $display("FAIL b2b_second: pv=%b nack=%b crc_ok=%b fields=%h required 1 1 1 fields=%h",
               pkt_valid, is_nack, crc_ok, obs, exp_fields);
    end
    checks++;
    if (t2 - t1 !== 79) begin
      failures++;
      $display("FAIL b2b_spacing: got %0d cycles required 79", t2 - t1);
    end
    idle(2);
  endtask

  task automatic test_reset_midframe;
    logic [78:0] f1, f2;
    logic [63:0] d;
    int pv0;
    my_address = 4'h5;
    d = {$urandom, $urandom};
    f1 = make_frame(4'h1, 4'h5, 2'b11, d, crc_for(d), 1'b1);
    pv0 = pv_count;
    for (int i = 78; i > 40; i--) begin
      serial_in = f1[i];
      @(negedge clk);
    end
    serial_in = f1[40];
    rst_n = 1'b0;
    @(negedge clk);
    serial_in = 1'b1;
    @(negedge clk);
    checks++;
    if ({pkt_valid, frame_err, busy, obs} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got pv=%b fe=%b busy=%b fields=%h required all zero",
               pkt_valid, frame_err, busy, obs);
    end
    rst_n = 1'b1;
    d = {$urandom, $urandom};
    f2 = make_frame(4'hc, 4'h5, 2'b00, d, crc_for(d), 1'b1);
    exp_fields = model(f2);
    send_frame(f2);
    checks++;
    if (pkt_valid !== 1'b1 || obs !== exp_fields) begin
      failures++;
      $display("FAIL midreset_new_frame: pv=%b fields=%h required pv=1 fields=%h", pkt_valid, obs, exp_fields);
    end
    idle(2);
    checks++;
    if (pv_count - pv0 !== 1) begin
      failures++;
      $display("FAIL midreset_pulse_count: got %0d required 1", pv_count - pv0);
    end
  endtask

  task automatic test_random;
    logic [78:0] f;
    logic [63:0] d;
    logic [3:0]  dst;
    logic [2:0]  crc;
    logic        stop;
    for (int n = 0; n < 24; n++) begin
      my_address = 4'($urandom);
      dst  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : my_address;
      d    = {$urandom, $urandom};
      crc  = ($urandom_range(0, 1) == 0) ? crc_for(d) : 3'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      f = make_frame(4'($urandom), dst, 2'($urandom), d, crc, stop);
      if (n == 5) f[67:1] = '1;
      send_frame(f);
      if (stop) begin
        exp_fields = model(f);
        checks++;
        if ({pkt_valid, frame_err} !== {(dst == my_address), 1'b0}) begin
          failures++;
          $display("FAIL rand_%0d_strobes: got pv=%b fe=%b required pv=%b fe=0", n, pkt_valid, frame_err, dst == my_address);
        end
      end else begin
        checks++;
        if ({pkt_valid, frame_err} !== 2'b01) begin
          failures++;
          $display("FAIL rand_%0d_stop_err: got pv=%b fe=%b required pv=0 fe=1", n, pkt_valid, frame_err);
        end
        idle(1);
      end
      checks++;
      if (obs !== exp_fields) begin
        failures++;
        $display("FAIL rand_%0d_fields: got %h required %h", n, obs, exp_fields);
      end
      idle($urandom_range(0, 3));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    serial_in = 1'b1;
    my_address = 4'h0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_crc_error();
    test_address_miss();
    test_frame_error();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/packet_receive.md
PACKET_RECEIVE -- requirements
Module: packet_receive

Interface
REQ-001 Parameter FRAME_LEN, 79, total serial frame length in bits, start bit through stop bit.
REQ-002 Parameter CRC_POLY, 4'b1001, CRC generator x^3+1; the remainder is 3 bits.
REQ-003 clk  input  1  sole clock; all logic updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 serial_in  input  1  bus line; idles high; frames are sent MSB first (bit 78 first).
REQ-006 my_address  input  4  local node address.
REQ-007 pkt_valid  output  1  one-cycle pulse: a well-framed packet addressed to my_address was captured.
REQ-008 src_addr  output  4  frame bits [77:74], the sender address.
REQ-009 dst_addr  output  4  frame bits [73:70], the destination address.
REQ-010 data_size  output  2  frame bits [69:68].
REQ-011 data_out  output  64  frame bits [67:4].
REQ-012 crc_ok  output  1  the 67-bit codeword [67:1] divides evenly by CRC_POLY.
REQ-013 is_ack / is_nack  output  1 each  the codeword is all ones / all zeros.
REQ-014 frame_err  output  1  one-cycle pulse: stop bit (frame bit 0) sampled low.
REQ-015 busy  output  1  high while the state is RECV or RESYNC.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RECV and RESYNC.
REQ-017 IDLE: serial_in==0 is the start bit (frame bit 78); the FSM SHALL go to RECV with bit_cnt=77.
REQ-018 RECV: each cycle the FSM SHALL shift serial_in into the frame register and decrement bit_cnt.
REQ-019 RECV, stop bit: the sample taken at bit_cnt==0 is the stop bit, and the frame is complete on that edge.
REQ-020 Stop bit 1: the FSM SHALL go to IDLE, and a start bit on the very next cycle SHALL be accepted (back-to-back frames).
REQ-021 Stop bit 0: the FSM SHALL pulse frame_err, go to RESYNC, leave the field outputs unchanged and not pulse pkt_valid.
REQ-022 RESYNC: the FSM SHALL stay until serial_in==1 is sampled, then go to IDLE.
REQ-023 CRC: a serial divider SHALL start from r=3'b000 at the start bit and, for each of frame bits 67..1, compute r <= {r[1:0],b} ^ (r[2] ? 3'b001 : 3'b000); crc_ok = (r==0) after bit 1.
REQ-024 Frame bits 78..68 and bit 0 SHALL NOT enter the CRC.
REQ-025 On the stop-bit edge with stop==1, the FSM SHALL register all field outputs, crc_ok, is_ack and is_nack, whatever the address.
REQ-026 pkt_valid SHALL be high in the cycle after the stop-bit edge only if dst_addr==my_address; latency from stop-bit sample to pkt_valid is 1 cycle.
REQ-027 crc_ok is reported with pkt_valid and SHALL NOT gate it; the consumer decides whether to send ack or nack.
REQ-028 Field outputs SHALL hold their values until the next good frame.
REQ-029 pkt_valid and frame_err SHALL never be high in the same cycle.
REQ-030 my_address SHALL be sampled on the stop-bit edge only.

Reset
REQ-031 When rst_n==0 at a rising clk edge: state=IDLE, bit_cnt=0, r=0, frame register all ones; all outputs 0.
REQ-032 Reset mid-frame SHALL discard the partial frame and produce no pulse.
REQ-033 After reset, a start bit on the first cycle with rst_n==1 SHALL be accepted.

Structure
REQ-034 Package packet_pkg SHALL hold: FRAME_LEN; field bit positions (SRC 77:74, DST 73:70, SIZE 69:68, DATA 67:4, CRC 3:1, STOP 0); CRC_POLY; the state enumeration. The transmitter and the packet builder share this package.
REQ-035 There SHALL be one sub-module, crc3_serial (inputs clk, rst_n, clr, en, bit_in; output rem[2:0]), instantiated once.

Verification
REQ-036 Frame with src=4'h2, dst=4'h5, size=2'b01, data=64'h1, crc=3'b001, stop=1; my_address=4'h5 -> pkt_valid 1 cycle after the stop bit, data_out=64'h1, crc_ok=1, is_ack=0, is_nack=0.
REQ-037 Same frame with data bit 4 flipped -> pkt_valid=1, crc_ok=0.
REQ-038 Same frame with my_address=4'h3 -> no pkt_valid, fields updated, dst_addr=4'h5.
REQ-039 Stop bit=0, then serial_in held low for 5 cycles -> frame_err pulse, busy stays high until serial_in=1, then IDLE, fields unchanged.
REQ-040 Two all-zero-codeword frames back-to-back (zero idle gap) -> two pkt_valid pulses 79 cycles apart, is_nack=1, crc_ok=1.
REQ-041 rst_n=0 at frame bit 40, released and a new frame sent -> exactly one pkt_valid, for the new frame only.
